// File: rtl/counter_pkg.sv
// Shared definitions for the loadable counter family: FSM state encoding and default width.
package counter_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/loadable_down_timer_tc_pulse_gen.sv
// Registers the terminal-count condition into a single-cycle pulse; abort suppresses it.
module tc_pulse_gen (
   input  logic clk,
   input  logic rst_n,
   input  logic tc_set,
   input  logic abort,
   output logic tc_pulse
);

   logic tc_q;

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tc_q <= 1'b0;
      else        tc_q <= tc_set & ~abort;
   end

   assign tc_pulse = tc_q;

endmodule

// File: rtl/loadable_down_timer.sv
// Loadable down-counting timer with valid/ready load, optional auto-reload and terminal-count pulse.
module loadable_down_timer
   import counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_val,
   input  logic             auto_reload,
   input  logic             enable,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc_pulse
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             mode_q, mode_d;
   logic             busy_q;
   logic             tc_set;
   logic             load_accept;

   assign load_ready  = (state_q != RUN);
   assign load_accept = load_valid & load_ready;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      tc_set   = 1'b0;

      if (abort) begin
         state_d = IDLE;
         count_d = '0;
         mode_d  = 1'b0;
      end else if (load_accept) begin
         count_d  = load_val;
         reload_d = load_val;
         mode_d   = auto_reload;
         if (load_val == '0) begin
            state_d = DONE;
            tc_set  = 1'b1;
         end else begin
            state_d = RUN;
         end
      end else begin
         unique case (state_q)
            IDLE: count_d = '0;
            DONE: count_d = '0;
            RUN: begin
               if (enable) begin
                  if (count_q > WIDTH'(1)) begin
                     count_d = count_q - WIDTH'(1);
                  end else if (count_q == WIDTH'(1)) begin
                     count_d = '0;
                     tc_set  = 1'b1;
                     if (!mode_q) state_d = DONE;
                  end else if (mode_q) begin
                     count_d = reload_q;
                  end else begin
                     // A zero count in one-shot mode cannot persist; settle in DONE.
                     state_d = DONE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         mode_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         busy_q   <= (state_d == RUN);
      end
   end

   tc_pulse_gen u_tc_pulse_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .tc_set   (tc_set),
      .abort    (abort),
      .tc_pulse (tc_pulse)
   );

   assign count = count_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_loadable_down_timer.sv
// Directed bench for loadable_down_timer: reset, one-shot, auto-reload, gating, zero load, abort, width limit.
module tb_loadable_down_timer;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_val;
   logic             auto_reload;
   logic             enable;
   logic             abort;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tc_pulse;

   int vectors     = 0;
   int miscompares = 0;

   loadable_down_timer #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_val    (load_val),
      .auto_reload (auto_reload),
      .enable      (enable),
      .abort       (abort),
      .count       (count),
      .busy        (busy),
      .tc_pulse    (tc_pulse)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [WIDTH-1:0] v, input logic ar);
      load_val    = v;
      auto_reload = ar;
      load_valid  = 1'b1;
      tick();
      load_valid  = 1'b0;
   endtask

   task automatic test_reset();
      vectors++; if (count !== 4'd0)     begin $display("FAIL rst_count got=%0d exp=0", count); miscompares++; end
      vectors++; if (busy !== 1'b0)      begin $display("FAIL rst_busy got=%b exp=0", busy); miscompares++; end
      vectors++; if (tc_pulse !== 1'b0)  begin $display("FAIL rst_tc got=%b exp=0", tc_pulse); miscompares++; end
      #3 rst_n = 1'b1;
      tick();
      vectors++; if (load_ready !== 1'b1) begin $display("FAIL rst_ready got=%b exp=1", load_ready); miscompares++; end
      // Mid-run asynchronous reset: load 9, three decrements, then reset between edges.
      do_load(4'd9, 1'b0);
      repeat (3) tick();
      vectors++; if (count !== 4'd6)     begin $display("FAIL midrun_pre got=%0d exp=6", count); miscompares++; end
      #3 rst_n = 1'b0;
      #1;
      vectors++; if (count !== 4'd0)     begin $display("FAIL midrun_count got=%0d exp=0", count); miscompares++; end
      vectors++; if (busy !== 1'b0)      begin $display("FAIL midrun_busy got=%b exp=0", busy); miscompares++; end
      vectors++; if (tc_pulse !== 1'b0)  begin $display("FAIL midrun_tc got=%b exp=0", tc_pulse); miscompares++; end
      #2 rst_n = 1'b1;
      tick();
      vectors++; if (load_ready !== 1'b1) begin $display("FAIL midrun_ready got=%b exp=1", load_ready); miscompares++; end
      vectors++; if (count !== 4'd0)     begin $display("FAIL midrun_hold got=%0d exp=0", count); miscompares++; end
   endtask

   task automatic test_one_shot();
      do_load(4'd5, 1'b0);
      vectors++; if (count !== 4'd5)      begin $display("FAIL os_load got=%0d exp=5", count); miscompares++; end
      vectors++; if (busy !== 1'b1)       begin $display("FAIL os_busy got=%b exp=1", busy); miscompares++; end
      vectors++; if (load_ready !== 1'b0) begin $display("FAIL os_ready got=%b exp=0", load_ready); miscompares++; end
      for (int i = 4; i >= 0; i--) begin
         tick();
         vectors++; if (count !== 4'(i)) begin $display("FAIL os_count cyc=%0d got=%0d exp=%0d", 5 - i, count, i); miscompares++; end
         vectors++; if (tc_pulse !== (i == 0)) begin $display("FAIL os_tc cyc=%0d got=%b exp=%b", 5 - i, tc_pulse, i == 0); miscompares++; end
      end
      vectors++; if (busy !== 1'b0)       begin $display("FAIL os_done_busy got=%b exp=0", busy); miscompares++; end
      vectors++; if (load_ready !== 1'b1) begin $display("FAIL os_done_ready got=%b exp=1", load_ready); miscompares++; end
      repeat (2) tick();
      vectors++; if (count !== 4'd0)      begin $display("FAIL os_hold got=%0d exp=0", count); miscompares++; end
      vectors++; if (tc_pulse !== 1'b0)   begin $display("FAIL os_tc_single got=%b exp=0", tc_pulse); miscompares++; end
   endtask

   task automatic test_auto_reload();
      logic [WIDTH-1:0] exp_seq [12] = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
      do_load(4'd3, 1'b1);
      vectors++; if (count !== 4'd3) begin $display("FAIL ar_load got=%0d exp=3", count); miscompares++; end
      for (int i = 0; i < 12; i++) begin
         tick();
         vectors++; if (count !== exp_seq[i]) begin $display("FAIL ar_count cyc=%0d got=%0d exp=%0d", i + 1, count, exp_seq[i]); miscompares++; end
         vectors++; if (tc_pulse !== (exp_seq[i] == 4'd0)) begin $display("FAIL ar_tc cyc=%0d got=%b exp=%b", i + 1, tc_pulse, exp_seq[i] == 4'd0); miscompares++; end
         vectors++; if (busy !== 1'b1) begin $display("FAIL ar_busy cyc=%0d got=%b exp=1", i + 1, busy); miscompares++; end
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      vectors++; if (count !== 4'd0)      begin $display("FAIL ar_abort_count got=%0d exp=0", count); miscompares++; end
      vectors++; if (busy !== 1'b0)       begin $display("FAIL ar_abort_busy got=%b exp=0", busy); miscompares++; end
      vectors++; if (load_ready !== 1'b1) begin $display("FAIL ar_abort_ready got=%b exp=1", load_ready); miscompares++; end
   endtask

   task automatic test_enable_gating();
      logic [WIDTH-1:0] exp_seq [7] = '{4'd3, 4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
      logic             en_seq  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_load(4'd4, 1'b0);
      // Enable value listed per step applies to the edge after the previous sample.
      for (int i = 0; i < 7; i++) begin
         enable     = (i == 0) ? 1'b1 : en_seq[i - 1];
         load_valid = (i >= 2 && i <= 4);
         load_val   = 4'd7;
         if (i >= 2 && i <= 4) begin
            vectors++; if (load_ready !== 1'b0) begin $display("FAIL eg_ready cyc=%0d got=%b exp=0", i + 1, load_ready); miscompares++; end
         end
         tick();
         vectors++; if (count !== exp_seq[i]) begin $display("FAIL eg_count cyc=%0d got=%0d exp=%0d", i + 1, count, exp_seq[i]); miscompares++; end
         vectors++; if (tc_pulse !== (i == 6)) begin $display("FAIL eg_tc cyc=%0d got=%b exp=%b", i + 1, tc_pulse, i == 6); miscompares++; end
      end
      load_valid = 1'b0;
      enable     = 1'b1;
   endtask

   task automatic test_zero_load_abort();
      do_load(4'd0, 1'b1);
      vectors++; if (tc_pulse !== 1'b1)   begin $display("FAIL zl_tc got=%b exp=1", tc_pulse); miscompares++; end
      vectors++; if (count !== 4'd0)      begin $display("FAIL zl_count got=%0d exp=0", count); miscompares++; end
      vectors++; if (busy !== 1'b0)       begin $display("FAIL zl_busy got=%b exp=0", busy); miscompares++; end
      tick();
      vectors++; if (tc_pulse !== 1'b0)   begin $display("FAIL zl_tc_off got=%b exp=0", tc_pulse); miscompares++; end
      vectors++; if (count !== 4'd0)      begin $display("FAIL zl_noreload got=%0d exp=0", count); miscompares++; end
      do_load(4'd2, 1'b0);
      tick();
      vectors++; if (count !== 4'd1)      begin $display("FAIL ab_pre got=%0d exp=1", count); miscompares++; end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      vectors++; if (tc_pulse !== 1'b0)   begin $display("FAIL ab_tc got=%b exp=0", tc_pulse); miscompares++; end
      vectors++; if (count !== 4'd0)      begin $display("FAIL ab_count got=%0d exp=0", count); miscompares++; end
      vectors++; if (busy !== 1'b0)       begin $display("FAIL ab_busy got=%b exp=0", busy); miscompares++; end
      tick();
      vectors++; if (tc_pulse !== 1'b0)   begin $display("FAIL ab_tc_late got=%b exp=0", tc_pulse); miscompares++; end
      // Abort wins over a simultaneous load.
      abort = 1'b1;
      do_load(4'd6, 1'b0);
      abort = 1'b0;
      vectors++; if (count !== 4'd0)      begin $display("FAIL ab_prio_count got=%0d exp=0", count); miscompares++; end
      vectors++; if (load_ready !== 1'b1) begin $display("FAIL ab_prio_ready got=%b exp=1", load_ready); miscompares++; end
   endtask

   task automatic test_width_boundary();
      do_load(4'd15, 1'b0);
      vectors++; if (count !== 4'd15) begin $display("FAIL wb_load got=%0d exp=15", count); miscompares++; end
      for (int i = 14; i >= 0; i--) begin
         tick();
         vectors++; if (count !== 4'(i)) begin $display("FAIL wb_count cyc=%0d got=%0d exp=%0d", 15 - i, count, i); miscompares++; end
         vectors++; if (tc_pulse !== (i == 0)) begin $display("FAIL wb_tc cyc=%0d got=%b exp=%b", 15 - i, tc_pulse, i == 0); miscompares++; end
      end
      // Back-to-back: reload from DONE during the pulse cycle.
      do_load(4'd2, 1'b0);
      vectors++; if (count !== 4'd2)  begin $display("FAIL b2b_count got=%0d exp=2", count); miscompares++; end
      vectors++; if (busy !== 1'b1)   begin $display("FAIL b2b_busy got=%b exp=1", busy); miscompares++; end
      repeat (3) tick();
      vectors++; if (count !== 4'd0)  begin $display("FAIL wb_nowrap got=%0d exp=0", count); miscompares++; end
      vectors++; if (tc_pulse !== 1'b0) begin $display("FAIL wb_tc_after got=%b exp=0", tc_pulse); miscompares++; end
   endtask

   initial begin
      rst_n       = 1'b0;
      load_valid  = 1'b0;
      load_val    = '0;
      auto_reload = 1'b0;
      enable      = 1'b1;
      abort       = 1'b0;
      #8;
      test_reset();
      test_one_shot();
      test_auto_reload();
      test_enable_gating();
      test_zero_load_abort();
      test_width_boundary();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
